// File: rtl/jk_pkg.sv
// Shared JK encodings and the per-bit next-state function used by the flop bank.
package jk_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   function automatic logic jk_next(input logic cur, input logic [1:0] jk);
      logic nxt;
      case (jk)
         JK_CLR:  nxt = 1'b0;
         JK_SET:  nxt = 1'b1;
         JK_TGL:  nxt = ~cur;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel: master flop, slave output, change pulse and saturating change counter.
module jk_cell
   import jk_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned MS_MODE   = 1,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic             load_val,
   input  logic             j,
   input  logic             k,
   input  logic             cnt_clr,
   output logic             q,
   output logic             q_bar,
   output logic             changed,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             master_q, master_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             slave_q, slave_bar_q;

   always_comb begin
      master_d = master_q;
      if (load) begin
         master_d = load_val;
      end else if (en) begin
         master_d = jk_next(master_q, {j, k});
      end
      changed_d = (master_d != master_q);

      cnt_d = cnt_q;
      sat_d = sat_q;
      // Clear beats a same-edge change; counter sticks at max instead of wrapping.
      if (cnt_clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (changed_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
         sat_d = (cnt_q == (CNT_MAX - CNT_W'(1)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         master_q  <= RESET_VAL;
         changed_q <= 1'b0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         master_q  <= master_d;
         changed_q <= changed_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
      end
   end

   if (MS_MODE != 0) begin : g_ms
      // Slave presents the master half a cycle later on the falling edge.
      always_ff @(negedge clk or posedge rst) begin
         if (rst) begin
            slave_q     <= RESET_VAL;
            slave_bar_q <= ~RESET_VAL;
         end else begin
            slave_q     <= master_q;
            slave_bar_q <= ~master_q;
         end
      end
   end else begin : g_se
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            slave_q     <= RESET_VAL;
            slave_bar_q <= ~RESET_VAL;
         end else begin
            slave_q     <= master_d;
            slave_bar_q <= ~master_d;
         end
      end
   end

   assign q       = slave_q;
   assign q_bar   = slave_bar_q;
   assign changed = changed_q;
   assign cnt     = cnt_q;
   assign sat     = sat_q;

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-channel JK flag bank with per-channel activity counters and counter readback mux.
module jk_ff_bank
   import jk_pkg::*;
#(
   parameter int unsigned       WIDTH     = 4,
   parameter int unsigned       CNT_W     = 8,
   parameter int unsigned       MS_MODE   = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       load,
   input  logic [WIDTH-1:0]           load_val,
   input  logic [WIDTH-1:0]           j,
   input  logic [WIDTH-1:0]           k,
   input  logic                       cnt_clr,
   input  logic [$clog2(WIDTH):0]     cnt_sel,
   output logic [WIDTH-1:0]           q,
   output logic [WIDTH-1:0]           q_bar,
   output logic [WIDTH-1:0]           changed,
   output logic [CNT_W-1:0]           toggle_cnt,
   output logic [WIDTH-1:0]           cnt_sat
);

   localparam int unsigned SEL_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0] cnt_arr [WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(
         .CNT_W     (CNT_W),
         .MS_MODE   (MS_MODE),
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .load     (load),
         .load_val (load_val[i]),
         .j        (j[i]),
         .k        (k[i]),
         .cnt_clr  (cnt_clr),
         .q        (q[i]),
         .q_bar    (q_bar[i]),
         .changed  (changed[i]),
         .cnt      (cnt_arr[i]),
         .sat      (cnt_sat[i])
      );
   end

   // Out-of-range selects read as zero.
   always_comb begin
      toggle_cnt = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (cnt_sel == SEL_W'(i)) begin
            toggle_cnt = cnt_arr[i];
         end
      end
   end

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: master-slave instance plus a single-edge instance on shared stimulus.
module tb_jk_ff_bank;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk;
   logic             rst;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             cnt_clr;
   logic [2:0]       cnt_sel;

   logic [WIDTH-1:0] q_ms, qb_ms, chg_ms, sat_ms;
   logic [CNT_W-1:0] cnt_ms;
   logic [WIDTH-1:0] q_se, qb_se, chg_se, sat_se;
   logic [CNT_W-1:0] cnt_se;

   int checks = 0;
   int errors = 0;

   jk_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MS_MODE(1), .RESET_VAL('0)) u_dut_ms (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .j(j), .k(k),
      .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .q(q_ms), .q_bar(qb_ms), .changed(chg_ms),
      .toggle_cnt(cnt_ms), .cnt_sat(sat_ms)
   );

   jk_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MS_MODE(0), .RESET_VAL('0)) u_dut_se (
      .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .j(j), .k(k),
      .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .q(q_se), .q_bar(qb_se), .changed(chg_se),
      .toggle_cnt(cnt_se), .cnt_sat(sat_se)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] exp_m;
   logic [WIDTH-1:0] exp_sat;
   int               exp_cnt;

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
      j = '0; k = '0; cnt_clr = 1'b0; cnt_sel = 3'd0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      neg();
      check("rst_q", q_ms, 4'h0);
      check("rst_qbar", qb_ms, 4'hF);
      check("rst_changed", chg_ms, 4'h0);
      check("rst_cnt", cnt_ms, 3'd0);
      check("rst_sat", sat_ms, 4'h0);

      // Set channel 0: master moves at posedge, MS slave only at the negedge
      en = 1'b1; j = 4'b0001; k = 4'b0000;
      pos();
      check("set_changed", chg_ms, 4'b0001);
      check("set_q_before_neg", q_ms, 4'b0000);
      check("set_se_q", q_se, 4'b0001);
      j = 4'b0000;
      neg();
      check("set_q_after_neg", q_ms, 4'b0001);
      check("set_qbar_after_neg", qb_ms, 4'b1110);
      pos();
      check("set_changed_drop", chg_ms, 4'b0000);
      check("set_cnt0", cnt_ms, 3'd1);

      // Toggle all channels nine times; counters saturate at 7
      j = 4'hF; k = 4'hF; cnt_sel = 3'd2;
      for (int n = 1; n <= 9; n++) begin
         exp_m   = (n % 2 == 1) ? 4'b1110 : 4'b0001;
         exp_cnt = (n < 7) ? n : 7;
         exp_sat = (n >= 7) ? 4'hF : ((n >= 6) ? 4'b0001 : 4'b0000);
         pos();
         check("tgl_changed", chg_ms, 4'hF);
         check("tgl_cnt2", cnt_ms, 32'(exp_cnt));
         check("tgl_sat", sat_ms, exp_sat);
         check("tgl_se_q", q_se, exp_m);
         neg();
         check("tgl_ms_q", q_ms, exp_m);
      end
      cnt_sel = 3'd4;
      #1 check("sel_out_of_range", cnt_ms, 3'd0);
      cnt_sel = 3'd0;
      #1 check("sel0_sat_val", cnt_ms, 3'd7);

      // Clear wins over a same-edge change; the next change counts from 1
      cnt_clr = 1'b1;
      pos();
      check("clr_changed", chg_ms, 4'hF);
      check("clr_cnt", cnt_ms, 3'd0);
      check("clr_sat", sat_ms, 4'h0);
      check("clr_se_q", q_se, 4'b0001);
      cnt_clr = 1'b0;
      pos();
      check("clr_next_cnt", cnt_ms, 3'd1);
      check("clr_next_se_q", q_se, 4'b1110);
      en = 1'b0; j = 4'h0; k = 4'h0;
      neg();
      check("clr_ms_q", q_ms, 4'b1110);

      // Asynchronous reset mid-cycle, released after a posedge
      rst = 1'b1;
      #1;
      check("arst_q", q_ms, 4'h0);
      check("arst_qbar", qb_ms, 4'hF);
      check("arst_changed", chg_ms, 4'h0);
      check("arst_cnt", cnt_ms, 3'd0);
      check("arst_sat", sat_ms, 4'h0);
      check("arst_se_q", q_se, 4'h0);
      pos();
      check("arst_held_q", q_ms, 4'h0);
      rst = 1'b0;
      neg();
      check("arst_rel_q", q_ms, 4'h0);
      check("arst_rel_qbar", qb_ms, 4'hF);

      // Load overrides en=0 and J/K
      load = 1'b1; load_val = 4'b1010; j = 4'hF; k = 4'hF;
      pos();
      check("load_changed", chg_ms, 4'b1010);
      check("load_q_before_neg", q_ms, 4'h0);
      check("load_se_q", q_se, 4'b1010);
      load = 1'b0;
      neg();
      check("load_q", q_ms, 4'b1010);
      check("load_qbar", qb_ms, 4'b0101);
      cnt_sel = 3'd1;
      #1 check("load_cnt1", cnt_ms, 3'd1);
      pos();
      check("hold_changed", chg_ms, 4'h0);
      check("hold_se_q", q_se, 4'b1010);
      neg();
      check("hold_ms_q", q_ms, 4'b1010);

      // Single-edge instance: set bit 2 appears at the same posedge
      en = 1'b1; j = 4'b0100; k = 4'b0000;
      pos();
      check("se_set_q", q_se, 4'b1110);
      check("se_set_qbar", qb_se, 4'b0001);
      check("se_ms_lag_q", q_ms, 4'b1010);
      neg();
      check("se_ms_q", q_ms, 4'b1110);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
